// File: rtl/rr_arbiter8way16_pkg.sv
// Shared sizing and state encoding for the 8-way round-robin arbiter.
package rr_arbiter8way16_pkg;

    localparam int N_REQ = 8;
    localparam int WIDTH = 16;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/Mux8Way16.sv
// 8-way 16-bit word multiplexer: out = {a..h}[sel].
module Mux8Way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    output logic [15:0] out
);

    always_comb begin
        unique case (sel)
            3'd0:    out = a;
            3'd1:    out = b;
            3'd2:    out = c;
            3'd3:    out = d;
            3'd4:    out = e;
            3'd5:    out = f;
            3'd6:    out = g;
            default: out = h;
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// Circular priority search: first set request strictly after ptr_i, wrapping 7->0.
module rr_pick
    import rr_arbiter8way16_pkg::*;
(
    input  logic [0:N_REQ-1] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;

    // Walk from farthest to nearest so the nearest hit after ptr_i wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = ptr_i + IDX_W'(k);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8way16.sv
// Round-robin arbiter: captures one requester word per slot into a
// registered valid/ready output stage, acking the requester combinationally.
module rr_arbiter8way16 #(
    parameter int WIDTH     = 16,
    parameter int RESET_PTR = 7
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [0:rr_arbiter8way16_pkg::N_REQ-1] req,
    input  logic [0:WIDTH-1]                       in0,
    input  logic [0:WIDTH-1]                       in1,
    input  logic [0:WIDTH-1]                       in2,
    input  logic [0:WIDTH-1]                       in3,
    input  logic [0:WIDTH-1]                       in4,
    input  logic [0:WIDTH-1]                       in5,
    input  logic [0:WIDTH-1]                       in6,
    input  logic [0:WIDTH-1]                       in7,
    output logic [0:rr_arbiter8way16_pkg::N_REQ-1] ack,
    output logic [0:WIDTH-1]                       out,
    output logic [0:rr_arbiter8way16_pkg::IDX_W-1] sel,
    output logic                                   valid,
    input  logic                                   ready
);

    import rr_arbiter8way16_pkg::*;

    state_t           stateQ, stateD;
    logic [IDX_W-1:0] ptrQ, ptrD;
    logic [IDX_W-1:0] selQ, selD;
    logic [WIDTH-1:0] outQ, outD;
    logic             pickFound;
    logic [IDX_W-1:0] pickIdx;
    logic [15:0]      muxWord;
    logic             captureSlot;

    rr_pick uPick (
        .req_i   (req),
        .ptr_i   (ptrQ),
        .found_o (pickFound),
        .idx_o   (pickIdx)
    );

    Mux8Way16 uMux (
        .a   (in0),
        .b   (in1),
        .c   (in2),
        .d   (in3),
        .e   (in4),
        .f   (in5),
        .g   (in6),
        .h   (in7),
        .sel (pickIdx),
        .out (muxWord)
    );

    // Ready only matters while a word is held; an empty stage always accepts.
    assign captureSlot = (stateQ == IDLE) || ready;

    always_comb begin
        stateD = stateQ;
        ptrD   = ptrQ;
        selD   = selQ;
        outD   = outQ;
        ack    = '0;
        if (!reset && captureSlot) begin
            if (pickFound) begin
                stateD       = HOLD;
                ptrD         = pickIdx;
                selD         = pickIdx;
                outD         = muxWord;
                ack[pickIdx] = 1'b1;
            end else begin
                stateD = IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ <= IDLE;
            ptrQ   <= IDX_W'(RESET_PTR);
            selQ   <= '0;
            outQ   <= '0;
        end else begin
            stateQ <= stateD;
            ptrQ   <= ptrD;
            selQ   <= selD;
            outQ   <= outD;
        end
    end

    assign valid = (stateQ == HOLD);
    assign out   = outQ;
    assign sel   = selQ;

endmodule

// File: doc/rr_arbiter8way16.md
RR_ARBITER8WAY16 -- requirements
Module: rr_arbiter8way16

Interface
REQ-001 SHALL have parameter: WIDTH, 16, data word width (only 16 supported).
REQ-002 SHALL have parameter: RESET_PTR, 7, last-granted index after reset, so requester 0 wins first.
REQ-003 SHALL have port: clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: req  input  [0:7]  per-requester request; held with data until matching ack.
REQ-006 SHALL have ports: in0..in7  input  [0:15] each  requester data words.
REQ-007 SHALL have port: ack  output  [0:7]  one-hot, one-cycle pulse marking capture of that requester's word.
REQ-008 SHALL have port: out  output  [0:15]  registered granted word.
REQ-009 SHALL have port: sel  output  [0:2]  index of requester whose word is on out.
REQ-010 SHALL have port: valid  output  1  out/sel hold a word not yet accepted.
REQ-011 SHALL have port: ready  input  1  downstream accept; transfer when valid and ready high in the same cycle.

Function
REQ-012 SHALL implement two states: IDLE (valid=0) and HOLD (valid=1).
REQ-013 SHALL open a capture slot in a cycle when state is IDLE, or when state is HOLD and ready=1.
REQ-014 SHALL, in a capture slot with any req bit set, pick the first set bit searching circularly from ptr+1 (mod 8), wrapping 7->0.
REQ-015 SHALL, on a capture, register the picked inN into out and its index into sel, set ptr to that index, and enter HOLD.
REQ-016 SHALL drive ack[i]=1 combinationally in the capture cycle only; at most one ack bit high per cycle.
REQ-017 SHALL give latency one cycle: req sampled in cycle t -> valid=1 with the word in cycle t+1.
REQ-018 SHALL, on a capture slot with no req set and state HOLD with ready=1, return to IDLE with valid=0.
REQ-019 SHALL keep out, sel, valid stable while valid=1 and ready=0, and issue no ack.
REQ-020 SHALL sustain one transfer per cycle while ready=1 and requests are pending.
REQ-021 SHALL ignore ready while in IDLE.
REQ-022 SHALL capture nothing for a req bit deasserted before its ack; no grant is remembered.
REQ-023 SHALL, when all 8 requesters hold req continuously, grant 0,1,...,7,0,... in that order.

Reset
REQ-024 SHALL, while reset=1 at a clock edge, set state IDLE, valid=0, out=0, sel=0, ptr=RESET_PTR, ack=0 combinationally.
REQ-025 SHALL discard a word held at reset mid-transfer; the discarded requester re-requests.

Structure
REQ-026 SHALL take N_REQ=8, WIDTH=16, IDX_W=3 and the IDLE/HOLD state encoding from a shared package.
REQ-027 SHALL isolate the circular priority search in one sub-module rr_pick (req, ptr -> found, idx).
REQ-028 SHALL select the captured word through the existing Mux8Way16 driven by the picked idx.

Verification
REQ-029 SHALL check: after reset, req=8'b1111_1111, ready=1 for 9 cycles -> sel 0..7 then 0, each ack one-hot, valid=1 from cycle 2.
REQ-030 SHALL check: only req[5] held, in5=16'hBEEF, ready=1 -> out=16'hBEEF, sel=5, back-to-back, ack[5] every cycle.
REQ-031 SHALL check: valid=1 with in2=16'h1234, ready=0 for 4 cycles -> out, sel, valid stable, ack=0; ready=1 -> next capture the same edge.
REQ-032 SHALL check: ptr=6, req[0] and req[7] set -> 7 granted before 0 (wrap-around).
REQ-033 SHALL check: reset=1 while valid=1, ready=0 -> next cycle valid=0, out=0, sel=0; next grant starts search at 0.
REQ-034 SHALL check: req[3] pulsed one cycle while HOLD with ready=0 -> no ack[3], no word from 3 ever appears.
